// File: rtl/hilo_mac_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply unit.
interface hilo_mac_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, abort, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_mac_unit.sv
// Multi-cycle multiply / multiply-accumulate unit owning the HI/LO register pair.
// Sign-magnitude shift-add multiplier retiring STEP multiplier bits per cycle.
module hilo_mac_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           reset,
    hilo_mac_unit_if.slave bus
);
    localparam int NSTEP = WIDTH / STEP;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam int PW    = 2 * WIDTH;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             done_q, done_nx;
    logic [WIDTH-1:0] hi_q, lo_q, hi_nx, lo_nx;
    logic             load, step_en;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    prod;
    logic             neg;
    logic             accum;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    result;

    // Most-negative input maps to 2^(WIDTH-1), which is still exact as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] s;
        s = v;
        return (is_signed && s < 0) ? $unsigned(-s) : v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic n);
        logic signed [PW-1:0] s;
        s = $signed(p);
        return n ? $unsigned(-s) : p;
    endfunction

    assign partial = mcand * PW'(mplier[STEP-1:0]);
    assign result  = (accum ? {hi_q, lo_q} : '0) + apply_sign(prod, neg);

    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= PW'(magnitude(bus.a, ~bus.op[0]));
            mplier <= magnitude(bus.b, ~bus.op[0]);
            prod   <= '0;
            neg    <= ~bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            accum  <= bus.op[1];
        end else if (step_en) begin
            prod   <= prod + partial;
            mcand  <= mcand << STEP;
            mplier <= mplier >> STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
            hi_q   <= hi_nx;
            lo_q   <= lo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        load     = 1'b0;
        step_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op[2]) begin
                        load     = 1'b1;
                        cnt_nx   = '0;
                        state_nx = CALC;
                    end else begin
                        // Register moves and the reserved code retire immediately.
                        done_nx = 1'b1;
                        case (bus.op)
                            OP_MTHI: hi_nx = bus.a;
                            OP_MTLO: lo_nx = bus.a;
                            OP_CLR: begin
                                hi_nx = '0;
                                lo_nx = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    step_en = 1'b1;
                    if (cnt == CW'(NSTEP - 1)) begin
                        cnt_nx   = '0;
                        state_nx = FIN;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
                if (!bus.abort) begin
                    {hi_nx, lo_nx} = result;
                    done_nx        = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_mac_unit.sv
// Scoreboard bench for hilo_mac_unit: one STEP=1 and one STEP=4 instance checked against a plain-arithmetic HI/LO model.
module tb_hilo_mac_unit;
    localparam int W  = 32;
    localparam int N1 = 32;
    localparam int N4 = 8;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           exp_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    txn_t q1[$];
    txn_t q4[$];
    logic [2*W-1:0] m_hl [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hilo_mac_unit_if #(.WIDTH(W)) if1 ();
    hilo_mac_unit_if #(.WIDTH(W)) if4 ();

    hilo_mac_unit #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    hilo_mac_unit #(.WIDTH(W), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

    // Architectural effect of one retired op on the 64-bit {HI,LO} pair.
    function automatic logic [2*W-1:0] ref_op(input logic [2*W-1:0] hl, input txn_t t);
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0] ua, ub;
        sa = $signed(t.a);
        sb = $signed(t.b);
        ua = {{W{1'b0}}, t.a};
        ub = {{W{1'b0}}, t.b};
        case (t.op)
            3'd0:    return sa * sb;
            3'd1:    return ua * ub;
            3'd2:    return hl + sa * sb;
            3'd3:    return hl + ua * ub;
            3'd4:    return {t.a, hl[W-1:0]};
            3'd5:    return {hl[2*W-1:W], t.a};
            3'd6:    return '0;
            default: return hl;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? if1.busy : if4.busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? if1.done : if4.done;
    endfunction

    function automatic logic [2*W-1:0] hl_of(input int sel);
        return (sel == 0) ? {if1.hi, if1.lo} : {if4.hi, if4.lo};
    endfunction

    task automatic retire(input int sel, input logic [63:0] hl, input logic bsy);
        txn_t t;
        if ((sel == 0 && q1.size() == 0) || (sel == 1 && q4.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL spurious_done dut%0d: got done=1 expected done=0", sel);
            return;
        end
        if (sel == 0) t = q1.pop_front();
        else          t = q4.pop_front();
        m_hl[sel] = ref_op(m_hl[sel], t);
        chk($sformatf("result_dut%0d_op%0d", sel, t.op), hl, m_hl[sel]);
        chk($sformatf("latency_dut%0d_op%0d", sel, t.op), 64'(cyc), 64'(t.exp_cyc));
        chk($sformatf("busy_at_done_dut%0d", sel), {63'd0, bsy}, 64'd0);
    endtask

    // Monitor: every done pulse retires the oldest outstanding request.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (if1.done) retire(0, {if1.hi, if1.lo}, if1.busy);
            if (if4.done) retire(1, {if4.hi, if4.lo}, if4.busy);
        end
    end

    task automatic drive(input int sel, input logic st, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ab);
        if (sel == 0) begin
            if1.start = st; if1.op = op; if1.a = a; if1.b = b; if1.abort = ab;
        end else begin
            if4.start = st; if4.op = op; if4.a = a; if4.b = b; if4.abort = ab;
        end
    endtask

    task automatic set_abort(input int sel, input logic v);
        if (sel == 0) if1.abort = v;
        else          if4.abort = v;
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (busy_of(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_of(sel)) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout dut%0d: busy still 1 after %0d cycles, expected 0", sel, n);
        end
    endtask

    task automatic issue(input int sel, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t t;
        int   n;
        wait_idle(sel);
        n = (sel == 0) ? N1 : N4;
        t.op = op;
        t.a = a;
        t.b = b;
        t.exp_cyc = cyc + 1 + (op[2] ? 0 : n + 1);
        if (sel == 0) q1.push_back(t);
        else          q4.push_back(t);
        drive(sel, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive(sel, 1'b0, op, a, b, 1'b0);
    endtask

    // n counts falling edges after start was raised; n=N+1 lands in FIN.
    task automatic abort_after(input int sel, input int n);
        repeat (n - 1) @(negedge clk);
        set_abort(sel, 1'b1);
        if (sel == 0) q1.delete(q1.size() - 1);
        else          q4.delete(q4.size() - 1);
        @(negedge clk);
        set_abort(sel, 1'b0);
        chk($sformatf("abort_busy_dut%0d", sel), {63'd0, busy_of(sel)}, 64'd0);
        chk($sformatf("abort_done_dut%0d", sel), {63'd0, done_of(sel)}, 64'd0);
        chk($sformatf("abort_hold_dut%0d", sel), hl_of(sel), m_hl[sel]);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_hl[0] = '0;
        m_hl[1] = '0;
        reset = 1'b0;
        drive(0, 1'b0, 3'd0, '0, '0, 1'b0);
        drive(1, 1'b0, 3'd0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_busy_dut%0d", s), {63'd0, busy_of(s)}, 64'd0);
            chk($sformatf("reset_done_dut%0d", s), {63'd0, done_of(s)}, 64'd0);
            chk($sformatf("reset_hilo_dut%0d", s), hl_of(s), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Signed and unsigned products of the same operands
        issue(0, 3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("busy_after_start", {63'd0, busy_of(0)}, 64'd1);
        chk("calc_hold", hl_of(0), 64'd0);
        wait_idle(0);
        chk("mult_neg", hl_of(0), 64'hFFFF_FFFF_FFFF_FFEB);
        issue(0, 3'd1, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_idle(0);
        chk("multu", hl_of(0), 64'h0000_0006_FFFF_FFEB);

        issue(0, 3'd4, 32'h0000_0000, 32'h0);
        issue(0, 3'd5, 32'hFFFF_FFFF, 32'h0);
        chk("mthi_mtlo", hl_of(0), 64'h0000_0000_FFFF_FFFF);
        issue(0, 3'd2, 32'h0000_0001, 32'h0000_0001);
        wait_idle(0);
        chk("madd_carry", hl_of(0), 64'h0000_0001_0000_0000);

        issue(0, 3'd4, 32'hFFFF_FFFF, 32'h0);
        issue(0, 3'd5, 32'hFFFF_FFFF, 32'h0);
        issue(0, 3'd3, 32'h0000_0001, 32'h0000_0001);
        wait_idle(0);
        chk("maddu_wrap", hl_of(0), 64'h0);
        issue(0, 3'd2, 32'h8000_0000, 32'h8000_0000);
        wait_idle(0);
        chk("madd_most_neg", hl_of(0), 64'h4000_0000_0000_0000);

        // Abort mid-CALC with an ignored start pulse while busy
        issue(0, 3'd0, 32'd5, 32'd5);
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 3'd4, 32'hDEAD_BEEF, 32'h0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 3'd4, 32'hDEAD_BEEF, 32'h0, 1'b0);
        abort_after(0, 6);
        repeat (40) @(negedge clk);
        chk("abort_final_hold", hl_of(0), 64'h4000_0000_0000_0000);

        issue(0, 3'd6, 32'h0, 32'h0);
        chk("clr", hl_of(0), 64'h0);
        issue(0, 3'd7, 32'h1234_5678, 32'h0);
        chk("reserved_nop", hl_of(0), 64'h0);

        // STEP=4: fast multiply, then back-to-back start on the done cycle
        issue(1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF);
        wait_idle(1);
        chk("step4_multu", hl_of(1), 64'h0000_0000_FFFE_0001);
        issue(1, 3'd0, 32'h0000_0003, 32'hFFFF_FFFE);
        chk("step4_back_to_back", {63'd0, busy_of(1)}, 64'd1);
        wait_idle(1);
        chk("step4_mult", hl_of(1), 64'hFFFF_FFFF_FFFF_FFFA);

        // Randomized traffic with occasional aborts in CALC or FIN
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 50; i++) begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 7));
                issue(s, op, rnd_operand(), rnd_operand());
                if (!op[2] && $urandom_range(0, 5) == 0)
                    abort_after(s, $urandom_range(1, ((s == 0) ? N1 : N4) + 1));
            end
            wait_idle(s);
        end

        // Asynchronous reset mid-CALC, observed between clock edges
        issue(0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, busy_of(0)}, 64'd0);
        chk("async_reset_hilo", hl_of(0), 64'd0);
        chk("async_reset_hilo4", hl_of(1), 64'd0);
        q1.delete();
        q4.delete();
        m_hl[0] = '0;
        m_hl[1] = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_hold", hl_of(0), 64'd0);

        issue(0, 3'd2, 32'hFFFF_FFFF, 32'h0000_0003);
        wait_idle(0);
        chk("post_reset_madd", hl_of(0), 64'hFFFF_FFFF_FFFF_FFFD);

        repeat (3) @(negedge clk);
        chk("queue1_drained", 64'(q1.size()), 64'd0);
        chk("queue4_drained", 64'(q4.size()), 64'd0);
        chk("final_model_dut0", hl_of(0), m_hl[0]);
        chk("final_model_dut1", hl_of(1), m_hl[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
